// File: rtl/dmem_lsu_if.sv
// Core-side request/response and memory-side bus bundle for the data-memory LSU.
// The LSU takes the slave view; the core/memory side takes the master view.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned,
    input  req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned,
    output req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: one outstanding access, lane steering,
// load extension, misalignment and timeout errors.
module dmem_lsu #(
  parameter int TIMEOUT = 16
) (
  input logic       clk,
  input logic       reset,
  dmem_lsu_if.slave io_bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_write;
  logic          r_uns;
  logic [1:0]    r_size;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic        w_accept;
  logic        w_bad;
  logic        w_busy;
  logic        w_tmo;
  logic        w_done;
  logic        w_issue;
  logic        w_resp;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_sh;
  logic [31:0] w_ld;

  assign w_accept = io_bus.req_valid && (r_state == IDLE);
  assign w_issue  = (r_state == ISSUE);
  assign w_resp   = (r_state == RESP);
  assign w_busy   = w_issue || (r_state == WAIT);
  assign w_tmo    = w_busy && (r_cnt == CW'(TIMEOUT - 1));
  assign w_done   = (r_state == WAIT) && io_bus.mem_rvalid;

  always_comb begin
    w_bad = 1'b0;
    case (io_bus.req_size)
      2'b00:   w_bad = 1'b0;
      2'b01:   w_bad = io_bus.req_addr[0];
      2'b10:   w_bad = |io_bus.req_addr[1:0];
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      r_state == IDLE: begin
        if (w_accept) w_next = w_bad ? RESP : ISSUE;
      end
      r_state == ISSUE: begin
        if (w_tmo)                 w_next = RESP;
        else if (io_bus.mem_gnt)   w_next = WAIT;
      end
      r_state == WAIT: begin
        if (w_done || w_tmo) w_next = RESP;
      end
      r_state == RESP: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_be = 4'b1111;
    w_wd = r_wdata;
    case (r_size)
      2'b00: begin
        w_be = 4'b0001 << r_addr[1:0];
        w_wd = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be = 4'b0011 << {r_addr[1], 1'b0};
        w_wd = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = r_wdata;
      end
    endcase
  end

  assign w_sh = io_bus.mem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ld = w_sh;
    case (r_size)
      2'b00:   w_ld = {{24{~r_uns & w_sh[7]}}, w_sh[7:0]};
      2'b01:   w_ld = {{16{~r_uns & w_sh[15]}}, w_sh[15:0]};
      default: w_ld = w_sh;
    endcase
  end

  // Bus outputs are gated by state so reset zeroes them immediately.
  assign io_bus.req_ready  = (r_state == IDLE);
  assign io_bus.mem_req    = w_issue;
  assign io_bus.mem_we     = w_issue & r_write;
  assign io_bus.mem_be     = w_issue ? w_be : 4'b0000;
  assign io_bus.mem_addr   = w_issue ? {r_addr[31:2], 2'b00} : 32'd0;
  assign io_bus.mem_wdata  = w_issue ? w_wd : 32'd0;
  assign io_bus.resp_valid = w_resp;
  assign io_bus.resp_err   = w_resp & r_err;
  assign io_bus.resp_rdata = w_resp ? r_rdata : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= io_bus.req_write;
        r_uns   <= io_bus.req_unsigned;
        r_size  <= io_bus.req_size;
        r_addr  <= io_bus.req_addr;
        r_wdata <= io_bus.req_wdata;
        r_rdata <= 32'd0;
        r_err   <= w_bad;
        r_cnt   <= '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + CW'(1);
      end
      // A response arriving on the last allowed cycle beats the timeout.
      if (w_done) begin
        r_rdata <= r_write ? 32'd0 : w_ld;
        r_err   <= 1'b0;
      end else if (w_tmo) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed testbench for dmem_lsu with a transaction-level reference model
// and a per-cycle compare process.
module tb_dmem_lsu;
  localparam int TMO = 16;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_pass;

  dmem_lsu_if bus ();

  dmem_lsu #(.TIMEOUT(TMO)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // model state for the transaction in flight
  logic        chk_en;
  logic        txn_on;
  int          acc_cyc;
  logic        e_legal;
  int          e_mreq_last;
  int          e_resp_cyc;
  logic [31:0] e_rdata;
  logic        e_err;
  logic [31:0] e_addr;
  logic [3:0]  e_be;
  logic        e_we;
  logic [31:0] e_wdata;

  // observations from the last transaction, for literal checks
  int          o_mreq_n;
  int          o_resp_rc;
  logic [31:0] o_rdata;
  logic        o_err;
  logic [3:0]  o_be;
  logic [31:0] o_wdata;
  logic [31:0] o_addr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic m_legal(input logic [1:0] sz,
                                   input logic [31:0] a);
    if (sz == 2'd3) return 1'b0;
    return (a % (32'd1 << sz)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz,
                                      input logic [31:0] a);
    int k;
    k = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << k);
    if (sz == 2'd1) return 4'(3 << k);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz,
                                       input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = {24'd0, d[7:0]};
    h = {16'd0, d[15:0]};
    if (sz == 2'd0) return b * 32'h0101_0101;
    if (sz == 2'd1) return h * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w,
                                         input logic [1:0] sz,
                                         input logic un,
                                         input logic [31:0] a);
    longint v;
    int k;
    k = int'(a % 4);
    v = longint'(w >> (8 * k));
    if (sz == 2'd0) begin
      v = v % 256;
      if (!un && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (!un && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  // per-cycle comparison against the model
  int   rc;
  logic eb;
  logic em;
  logic er;
  always @(negedge clk) begin
    if (chk_en) begin
      rc = cyc - acc_cyc;
      eb = txn_on && rc >= 1 && rc <= e_resp_cyc;
      em = txn_on && e_legal && rc >= 1 && rc <= e_mreq_last;
      er = txn_on && rc == e_resp_cyc;
      chk("req_ready", 32'(bus.req_ready), 32'(!eb));
      chk("mem_req", 32'(bus.mem_req), 32'(em));
      chk("resp_valid", 32'(bus.resp_valid), 32'(er));
      if (em) begin
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_be", 32'(bus.mem_be), 32'(e_be));
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        chk("mem_wdata", bus.mem_wdata, e_wdata);
      end
      if (er) begin
        chk("resp_rdata", bus.resp_rdata, e_rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(e_err));
      end
    end
  end

  task automatic idle_in();
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    bus.mem_gnt      = 1'b0;
    bus.mem_rvalid   = 1'b0;
    bus.mem_rdata    = 32'd0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_mreq"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_mwe"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mbe"}, 32'(bus.mem_be), 32'd0);
    chk({tag, "_maddr"}, bus.mem_addr, 32'd0);
    chk({tag, "_mwdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_rvalid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_rerr"}, 32'(bus.resp_err), 32'd0);
    chk({tag, "_rdata"}, bus.resp_rdata, 32'd0);
  endtask

  // gd: gnt delay in ISSUE; rd: rvalid delay in WAIT (-1 = never)
  task automatic txn(input logic w, input logic [1:0] sz, input logic un,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int gd, input int rd, input logic [31:0] mrd,
                     input int rst_at);
    int need;
    int rvc;
    @(posedge clk);
    #1;
    e_legal     = m_legal(sz, a);
    e_addr      = a & 32'hFFFF_FFFC;
    e_be        = m_be(sz, a);
    e_we        = w;
    e_wdata     = m_wd(sz, wd);
    rvc         = (rd >= 0) ? 2 + gd + rd : -1;
    need        = (rd >= 0) ? gd + rd + 2 : 1000;
    e_mreq_last = 0;
    if (!e_legal) begin
      e_resp_cyc = 1;
      e_err      = 1'b1;
      e_rdata    = 32'd0;
    end else begin
      e_mreq_last = (gd + 1 < TMO) ? gd + 1 : TMO;
      if (need <= TMO) begin
        e_resp_cyc = need + 1;
        e_err      = 1'b0;
        e_rdata    = w ? 32'd0 : m_load(mrd, sz, un, a);
      end else begin
        e_resp_cyc = TMO + 1;
        e_err      = 1'b1;
        e_rdata    = 32'd0;
      end
    end
    acc_cyc          = cyc;
    txn_on           = 1'b1;
    o_mreq_n         = 0;
    o_resp_rc        = -1;
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = un;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    for (int r = 1; r <= e_resp_cyc + 2; r++) begin
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.req_addr   = 32'hFFFF_FFFF;
      bus.req_wdata  = 32'h5555_AAAA;
      bus.mem_gnt    = e_legal && r == gd + 1;
      // stray rvalid while still in ISSUE, and one late pulse in IDLE
      bus.mem_rvalid = (r == rvc) || (r == e_resp_cyc + 1) ||
                       (e_legal && r < gd + 1);
      bus.mem_rdata  = (r == rvc) ? mrd : 32'hA5A5_5A5A;
      if (bus.mem_req) begin
        o_mreq_n++;
        o_be    = bus.mem_be;
        o_wdata = bus.mem_wdata;
        o_addr  = bus.mem_addr;
      end
      if (bus.resp_valid) begin
        o_resp_rc = r;
        o_rdata   = bus.resp_rdata;
        o_err     = bus.resp_err;
      end
      if (r == rst_at) begin
        #2;
        rst_n = 1'b0;
        txn_on = 1'b0;
        #1;
        chk_zero("rst_wait");
        idle_in();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
    end
    idle_in();
  endtask

  initial begin
    cyc    = 0;
    n_chk  = 0;
    n_pass = 0;
    chk_en = 1'b0;
    txn_on = 1'b0;
    acc_cyc = 0;
    e_resp_cyc = 0;
    e_mreq_last = 0;
    e_legal = 1'b0;
    rst_n  = 1'b1;
    idle_in();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("por");
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // signed byte load, immediate gnt/rvalid
    txn(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 0, 0, 32'h80FF_1234, -1);
    chk("lb_addr", o_addr, 32'h100);
    chk("lb_be", 32'(o_be), 32'h8);
    chk("lb_rdata", o_rdata, 32'hFFFF_FF80);
    chk("lb_lat", 32'(o_resp_rc), 32'd3);

    txn(1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 0, 0, 32'h80FF_1234, -1);
    chk("lbu_rdata", o_rdata, 32'h0000_0080);

    // halfword store, gnt delayed 3 cycles
    txn(1'b1, 2'd1, 1'b0, 32'h202, 32'hDEAD_BEEF, 3, 0, 32'd0, -1);
    chk("sh_mreq_n", 32'(o_mreq_n), 32'd4);
    chk("sh_be", 32'(o_be), 32'hC);
    chk("sh_wdata", o_wdata, 32'hBEEF_BEEF);
    chk("sh_err", 32'(o_err), 32'd0);

    // misaligned word load
    txn(1'b0, 2'd2, 1'b0, 32'h101, 32'd0, 0, 0, 32'd0, -1);
    chk("lw_mis_mreq", 32'(o_mreq_n), 32'd0);
    chk("lw_mis_lat", 32'(o_resp_rc), 32'd1);
    chk("lw_mis_err", 32'(o_err), 32'd1);

    // timeout with no rvalid, late rvalid in IDLE
    txn(1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 0, -1, 32'hFFFF_FFFF, -1);
    chk("tmo_err", 32'(o_err), 32'd1);
    chk("tmo_rdata", o_rdata, 32'd0);
    chk("tmo_lat", 32'(o_resp_rc), 32'd17);

    // rvalid on the last allowed cycle wins
    txn(1'b0, 2'd2, 1'b0, 32'h204, 32'd0, 0, 14, 32'h1234_5678, -1);
    chk("edge_err", 32'(o_err), 32'd0);
    chk("edge_rdata", o_rdata, 32'h1234_5678);
    txn(1'b0, 2'd2, 1'b0, 32'h208, 32'd0, 0, 15, 32'h1234_5678, -1);
    chk("late_err", 32'(o_err), 32'd1);

    // halfword loads, both lanes
    txn(1'b0, 2'd1, 1'b0, 32'h302, 32'd0, 1, 2, 32'h8001_7FFF, -1);
    chk("lh_hi", o_rdata, 32'hFFFF_8001);
    txn(1'b0, 2'd1, 1'b0, 32'h300, 32'd0, 0, 0, 32'h8001_7FFF, -1);
    chk("lh_lo", o_rdata, 32'h0000_7FFF);

    // byte and word stores
    txn(1'b1, 2'd0, 1'b0, 32'h401, 32'h1234_5678, 0, 1, 32'hFFFF_FFFF, -1);
    chk("sb_be", 32'(o_be), 32'h2);
    chk("sb_wdata", o_wdata, 32'h7878_7878);
    chk("sb_rdata", o_rdata, 32'd0);
    txn(1'b1, 2'd2, 1'b0, 32'h500, 32'hCAFE_F00D, 0, 0, 32'd0, -1);
    chk("sw_be", 32'(o_be), 32'hF);
    chk("sw_wdata", o_wdata, 32'hCAFE_F00D);

    // reserved size and misaligned half
    txn(1'b0, 2'd3, 1'b0, 32'h600, 32'd0, 0, 0, 32'd0, -1);
    chk("rsv_err", 32'(o_err), 32'd1);
    txn(1'b0, 2'd1, 1'b0, 32'h601, 32'd0, 0, 0, 32'd0, -1);
    chk("lh_mis_err", 32'(o_err), 32'd1);

    // reset while in WAIT, then a clean load
    txn(1'b0, 2'd2, 1'b0, 32'h700, 32'd0, 0, 10, 32'h1111_2222, 3);
    txn(1'b0, 2'd0, 1'b1, 32'h102, 32'd0, 0, 0, 32'h00AB_0000, -1);
    chk("post_rst_rdata", o_rdata, 32'h0000_00AB);
    chk("post_rst_lat", 32'(o_resp_rc), 32'd3);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
